// File: rtl/fifo_frame_pkg.sv
// fifo_frame_pkg: shared types and word builders for the frame packer.
// Provides the FSM state enum, header/footer magic bytes and 16-bit
// header/footer word builders (callers zero-extend to the stream width).
package fifo_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_FOOTER
    } state_t;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;
    localparam logic [7:0] FTR_MAGIC = 8'h5A;

    function automatic logic [15:0] hdr_word(input logic [7:0] cnt);
        return {HDR_MAGIC, cnt};
    endfunction

    function automatic logic [15:0] ftr_word(input logic [7:0] cnt);
        return {FTR_MAGIC, cnt};
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// axis_out_reg: single-entry output register slice for a valid/ready stream.
// Ports: clk, resetn (sync, active-low); load/load_data/load_last write the
// slot; ready from the sink; valid/data/last drive the sink; slot_free says
// a load this cycle is safe (slot empty or being drained).
module axis_out_reg #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last,
    output logic                  slot_free
);

    assign slot_free = !valid || ready;

    // data/last are only written on load, so they hold while stalled
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_frame_packer.sv
// fifo_frame_packer: pops an FWFT sample FIFO (max one pop per two cycles)
// and emits header/payload/footer frames on a valid/ready/last stream.
// Ports: CLK, RESETN (sync, active-low); FIFO_DOUT/FIFO_NOT_EMPTY/FIFO_RE
// on the FIFO side; M_TDATA/M_TVALID/M_TREADY/M_TLAST stream; PARTIAL
// pulses after a timeout footer is accepted; FRAME_CNT counts frames.
module fifo_frame_packer
    import fifo_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic [DATA_WIDTH-1:0] FIFO_DOUT,
    input  logic                  FIFO_NOT_EMPTY,
    output logic                  FIFO_RE,
    output logic [DATA_WIDTH-1:0] M_TDATA,
    output logic                  M_TVALID,
    input  logic                  M_TREADY,
    output logic                  M_TLAST,
    output logic                  PARTIAL,
    output logic [7:0]            FRAME_CNT
);

    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);
    localparam logic [7:0]    PAY_LAST  = 8'(FRAME_LEN - 1);

    state_t state;
    state_t state_nxt;

    logic [7:0]            pay_cnt;
    logic [IW-1:0]         idle_cnt;
    logic                  re_q;
    logic                  timeout_flag;
    logic                  ftr_sent;
    logic                  pop;
    logic                  timeout_hit;
    logic                  ftr_done;
    logic                  slot_free;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;

    // re_q blocks the pop after a pop: the not-empty flag is stale then
    assign pop = (state == ST_PAYLOAD) && FIFO_NOT_EMPTY
              && !re_q && slot_free;
    assign FIFO_RE = pop && RESETN;

    // the idle cycle that would bring idle_cnt to TIMEOUT; a pop wins
    assign timeout_hit = (state == ST_PAYLOAD) && !pop
                      && (idle_cnt == IDLE_LAST);

    always_ff @(posedge CLK) begin
        if (!RESETN) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_data = '0;
        load_last = 1'b0;
        ftr_done  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (FIFO_NOT_EMPTY) state_nxt = ST_HEADER;
            end
            ST_HEADER: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = DATA_WIDTH'(hdr_word(FRAME_CNT));
                    state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (pop) begin
                    load      = 1'b1;
                    load_data = FIFO_DOUT;
                    if (pay_cnt == PAY_LAST) state_nxt = ST_FOOTER;
                end else if (timeout_hit) begin
                    state_nxt = ST_FOOTER;
                end
            end
            ST_FOOTER: begin
                // first load the footer, then wait for its handshake
                if (!ftr_sent) begin
                    if (slot_free) begin
                        load      = 1'b1;
                        load_data = DATA_WIDTH'(ftr_word(pay_cnt));
                        load_last = 1'b1;
                    end
                end else if (M_TVALID && M_TREADY) begin
                    ftr_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            pay_cnt      <= '0;
            idle_cnt     <= '0;
            re_q         <= 1'b0;
            timeout_flag <= 1'b0;
            ftr_sent     <= 1'b0;
            PARTIAL      <= 1'b0;
            FRAME_CNT    <= '0;
        end else begin
            re_q    <= pop;
            PARTIAL <= ftr_done && timeout_flag;
            if (state != ST_PAYLOAD || pop)
                idle_cnt <= '0;
            else if (idle_cnt != IDLE_MAX)
                idle_cnt <= idle_cnt + IW'(1);
            if (ftr_done) begin
                FRAME_CNT    <= FRAME_CNT + 8'd1;
                pay_cnt      <= '0;
                timeout_flag <= 1'b0;
                ftr_sent     <= 1'b0;
            end else begin
                if (pop)         pay_cnt      <= pay_cnt + 8'd1;
                if (timeout_hit) timeout_flag <= 1'b1;
                if (state == ST_FOOTER && load) ftr_sent <= 1'b1;
            end
        end
    end

    axis_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out (
        .clk       (CLK),
        .resetn    (RESETN),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .ready     (M_TREADY),
        .valid     (M_TVALID),
        .data      (M_TDATA),
        .last      (M_TLAST),
        .slot_free (slot_free)
    );

endmodule
